// File: rtl/spy_round_controller.sv
// Round sequencer for the two-player Morse spy game: gates entry, clears datapaths,
// compares codes, keeps scores/rounds. Optional timeout via `define ROUND_TIMER_EN.
// Ports: clock, resetn (sync, active-high), start, p1_done, p2_done, p1_value,
//  p2_value -> p1/p2_enable, p1/p2_clear, state, round, p1/p2_score, match,
//  timed_out, game_over.
module spy_round_controller #(
  parameter int NUM_ROUNDS     = 5,
  parameter int SCORE_W        = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               p1_done,
  input  logic               p2_done,
  input  logic [9:0]         p1_value,
  input  logic [9:0]         p2_value,
  output logic               p1_enable,
  output logic               p2_enable,
  output logic               p1_clear,
  output logic               p2_clear,
  output logic [2:0]         state,
  output logic [3:0]         round,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match,
  output logic               timed_out,
  output logic               game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    P1_ENTRY  = 3'd1,
    P2_ENTRY  = 3'd2,
    COMPARE   = 3'd3,
    RESULT    = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         ROUNDS    = 4'(NUM_ROUNDS);

  state_t               state_q;
  logic [3:0]           round_q;
  logic [SCORE_W-1:0]   p1_score_q, p2_score_q;
  logic [SCORE_W-1:0]   p1_score_d, p2_score_d;
  logic                 match_q, timed_out_q;
  logic                 p1_clear_q, p2_clear_q;
  logic [9:0]           secret_q, guess_q;
  logic                 hit;

`ifdef ROUND_TIMER_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmr_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // A timed-out round always counts as a miss for player 2.
  assign hit = (guess_q == secret_q) && !timed_out_q;

  assign p1_score_d = (p1_score_q == SCORE_MAX) ? p1_score_q
                    : p1_score_q + SCORE_W'(1);
  assign p2_score_d = (p2_score_q == SCORE_MAX) ? p2_score_q
                    : p2_score_q + SCORE_W'(1);

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q     <= IDLE;
      round_q     <= '0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      match_q     <= 1'b0;
      timed_out_q <= 1'b0;
      p1_clear_q  <= 1'b0;
      p2_clear_q  <= 1'b0;
      secret_q    <= '0;
      guess_q     <= '0;
`ifdef ROUND_TIMER_EN
      tmr_q       <= '0;
`endif
    end else begin
      p1_clear_q <= 1'b0;
      p2_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= P1_ENTRY;
            p1_clear_q <= 1'b1;
            p2_clear_q <= 1'b1;
            round_q    <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
          end
        end
        P1_ENTRY: begin
          if (p1_done && p1_value != 10'd0) begin
            state_q    <= P2_ENTRY;
            secret_q   <= p1_value;
            p2_clear_q <= 1'b1;
`ifdef ROUND_TIMER_EN
            tmr_q      <= '0;
`endif
          end
        end
        P2_ENTRY: begin
          if (p2_done) begin
            state_q <= COMPARE;
            guess_q <= p2_value;
          end
`ifdef ROUND_TIMER_EN
          else if (tmr_q == TMR_LAST) begin
            state_q     <= COMPARE;
            timed_out_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
`endif
        end
        COMPARE: begin
          state_q <= RESULT;
          match_q <= hit;
          round_q <= round_q + 4'd1;
          if (hit) p2_score_q <= p2_score_d;
          else     p1_score_q <= p1_score_d;
        end
        RESULT: begin
          if (round_q == ROUNDS) begin
            state_q     <= GAME_OVER;
            timed_out_q <= 1'b0;
          end else if (start) begin
            state_q     <= P1_ENTRY;
            p1_clear_q  <= 1'b1;
            p2_clear_q  <= 1'b1;
            timed_out_q <= 1'b0;
          end
        end
        GAME_OVER: state_q <= GAME_OVER;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign p1_enable = (state_q == P1_ENTRY);
  assign p2_enable = (state_q == P2_ENTRY);
  assign game_over = (state_q == GAME_OVER);
  assign p1_clear  = p1_clear_q;
  assign p2_clear  = p2_clear_q;
  assign state     = state_q;
  assign round     = round_q;
  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign match     = match_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_spy_round_controller.sv
// Scoreboard bench for spy_round_controller: expected state transitions are
// queued by the stimulus and popped by a monitor on every observed change.
module tb_spy_round_controller;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       p1_done = 1'b0;
  logic       p2_done = 1'b0;
  logic [9:0] p1_value = '0;
  logic [9:0] p2_value = '0;
  logic       p1_enable, p2_enable, p1_clear, p2_clear;
  logic [2:0] state;
  logic [3:0] round;
  logic [3:0] p1_score, p2_score;
  logic       match, timed_out, game_over;

  spy_round_controller #(
    .NUM_ROUNDS(2), .SCORE_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .p1_done(p1_done), .p2_done(p2_done),
    .p1_value(p1_value), .p2_value(p2_value),
    .p1_enable(p1_enable), .p2_enable(p2_enable),
    .p1_clear(p1_clear), .p2_clear(p2_clear),
    .state(state), .round(round),
    .p1_score(p1_score), .p2_score(p2_score),
    .match(match), .timed_out(timed_out), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    bit         full;
    logic [3:0] rnd;
    logic [3:0] p1s;
    logic [3:0] p2s;
    logic       m;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_st(input logic [2:0] s);
    exp_t e;
    e = '{st: s, full: 1'b0, rnd: 0, p1s: 0, p2s: 0, m: 0, to: 0};
    q.push_back(e);
  endtask

  task automatic push_full(input logic [2:0] s, input logic [3:0] r,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic m, input logic to);
    exp_t e;
    e = '{st: s, full: 1'b1, rnd: r, p1s: a, p2s: b, m: m, to: to};
    q.push_back(e);
  endtask

  // Monitor: every state change is an output event checked against the queue.
  initial begin
    logic [2:0] prev;
    exp_t e;
    wait (mon_on);
    prev = state;
    forever begin
      @(negedge clock);
      if (state !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_transition", {29'd0, state}, {29'd0, prev});
        end else begin
          e = q.pop_front();
          chk("state_seq", {29'd0, state}, {29'd0, e.st});
          if (e.full) begin
            chk("round", {28'd0, round}, {28'd0, e.rnd});
            chk("p1_score", {28'd0, p1_score}, {28'd0, e.p1s});
            chk("p2_score", {28'd0, p2_score}, {28'd0, e.p2s});
            chk("match", {31'd0, match}, {31'd0, e.m});
            chk("timed_out", {31'd0, timed_out}, {31'd0, e.to});
          end
        end
        prev = state;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_outs", {28'd0, p1_enable, p2_enable, p1_clear, p2_clear},
        32'd0);
    chk("rst_scores", {24'd0, p1_score, p2_score}, 32'd0);
    chk("rst_round", {28'd0, round}, 32'd0);
    mon_on = 1'b1;
    tick();

    // Round 1: correct decode, clears pulse exactly one cycle.
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_clears", {30'd0, p1_clear, p2_clear}, 32'd3);
    chk("p1_en", {30'd0, p1_enable, p2_enable}, 32'd2);
    tick();
    chk("clears_1cyc", {30'd0, p1_clear, p2_clear}, 32'd0);
    push_st(3'd2);
    p1_value = 10'h1D7;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    chk("p2_clear", {30'd0, p1_clear, p2_clear}, 32'd1);
    chk("p2_en", {30'd0, p1_enable, p2_enable}, 32'd1);
    tick();
    chk("p2_clear_1cyc", {31'd0, p2_clear}, 32'd0);
    push_st(3'd3);
    push_full(3'd4, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0);
    p2_value = 10'h1D7;
    p2_done = 1'b1; tick(); p2_done = 1'b0;
    chk("lat_compare", {29'd0, state}, 32'd3);
    tick();
    chk("lat_result", {29'd0, state}, 32'd4);
    chk("lat_p2_score", {28'd0, p2_score}, 32'd1);
    tick();

    // Round 2: ignored inputs, then a wrong guess.
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("next_clears", {30'd0, p1_clear, p2_clear}, 32'd3);
    p1_value = 10'h000;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    chk("zero_secret_ign", {29'd0, state}, 32'd1);
    p2_done = 1'b1; tick(); p2_done = 1'b0;
    chk("p2_done_ign", {29'd0, state}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ign", {29'd0, state}, 32'd1);
    push_st(3'd2);
    p1_value = 10'h005;
    p1_done = 1'b1; p2_done = 1'b1; tick();
    p1_done = 1'b0; p2_done = 1'b0;
    chk("both_done_p1", {29'd0, state}, 32'd2);
    p1_value = 10'h3FF;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    chk("p1_done_ign", {29'd0, state}, 32'd2);
    push_st(3'd3);
    push_full(3'd4, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0);
    push_full(3'd5, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0);
    p2_value = 10'h007;
    p2_done = 1'b1; tick(); p2_done = 1'b0;
    tick(); tick();
    chk("game_over", {31'd0, game_over}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("go_start_ign", {29'd0, state}, 32'd5);
    chk("go_enables", {30'd0, p1_enable, p2_enable}, 32'd0);

    // New game: zero guess, then reset in the middle of P2_ENTRY.
    push_st(3'd0);
    resetn = 1'b1; tick(); resetn = 1'b0;
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    push_st(3'd2);
    p1_value = 10'h3FF;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    push_st(3'd3);
    push_full(3'd4, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    p2_value = 10'h000;
    p2_done = 1'b1; tick(); p2_done = 1'b0;
    tick();
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    push_st(3'd2);
    p1_value = 10'h2AA;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    push_st(3'd0);
    resetn = 1'b1; start = 1'b1; p2_done = 1'b1; tick();
    resetn = 1'b0; start = 1'b0; p2_done = 1'b0;
    chk("midrst_state", {29'd0, state}, 32'd0);
    chk("midrst_scores", {24'd0, p1_score, p2_score}, 32'd0);
    chk("midrst_round", {28'd0, round}, 32'd0);
    chk("midrst_outs", {28'd0, p1_enable, p2_enable, p1_clear, p2_clear},
        32'd0);
    tick();

`ifdef ROUND_TIMER_EN
    // Timeout round, then p2_done on the last count cycle.
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    push_st(3'd2);
    p1_value = 10'h011;
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    push_st(3'd3);
    push_full(3'd4, 4'd1, 4'd1, 4'd0, 1'b0, 1'b1);
    p2_value = 10'h011;
    for (int i = 0; i < 7; i++) tick();
    chk("tmr_wait", {29'd0, state}, 32'd2);
    tick();
    chk("tmr_expire", {29'd0, state}, 32'd3);
    tick();
    chk("tmr_flag", {31'd0, timed_out}, 32'd1);
    push_st(3'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("tmr_flag_clr", {31'd0, timed_out}, 32'd0);
    push_st(3'd2);
    p1_done = 1'b1; tick(); p1_done = 1'b0;
    push_st(3'd3);
    push_full(3'd4, 4'd2, 4'd1, 4'd1, 1'b1, 1'b0);
    push_full(3'd5, 4'd2, 4'd1, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    p2_done = 1'b1; tick(); p2_done = 1'b0;
    tick(); tick();
`endif

    tick(); tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
